serial_4bits_subtractor: RTL
============================

# serial_4bits_subtractor

Bit-serial 4-bit subtractor computing D = X − Y − Bin, one bit per clock, LSB first, with a start/busy/done handshake. It is the subtracting counterpart of the lab's parallel 4-bit ripple adder. It sits beside that adder in the arithmetic lab set as a sequential datapath exercise. It also serves as a low-area alternative where a 4-cycle latency is acceptable.

## Interface
- No parameters; operand width is fixed at 4 bits.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- X  input  4  minuend; captured on the accepted start edge.
- Y  input  4  subtrahend; captured on the accepted start edge.
- Bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (states S0–S3).
- done  output  1  one-cycle pulse; high exactly while in DONE.
- D  output  4  difference; registered, held until the next completion.
- Bout  output  1  unsigned borrow-out; registered and held.
- V  output  1  two's-complement overflow; registered and held.

## Operation
- States: IDLE, S0, S1, S2, S3, DONE. Encoding is free. No unreachable state may lock up; any illegal state returns to IDLE.
- IDLE: when start=1, latch X, Y, Bin into internal operand shift registers and the borrow flop, then go to S0. When start=0, stay in IDLE.
- Si (i = 0..3): compute bit i only:
  - d = x ^ y ^ b
  - b_next = (~x & y) | (~(x ^ y) & b)
  - Shift d into the difference shift register. Update the borrow flop. Advance to S(i+1), or from S3 to DONE.
- Leaving S3: load D with the full 4-bit difference, Bout with the final borrow, and V = (Xl[3] ^ Yl[3]) & (D[3] ^ Xl[3]), where Xl and Yl are the latched operands. All three load on the same edge.
- DONE: done=1.
  - If start=1, latch new operands and go to S0 (back-to-back operation).
  - Otherwise go to IDLE.
  - D, Bout and V stay unchanged until the next S3→DONE edge.
- A start asserted in S0–S3 is ignored. It is not queued.
- Input changes on X, Y or Bin after the accepted start edge do not affect the operation in flight.
- Arithmetic rules:
  - Result is modulo 16.
  - Bout=1 if and only if X < Y + Bin as unsigned values.
  - V is defined for signed 4-bit operands only.
- Reset, in any state including mid-operation: go to IDLE and clear all state. busy=0, done=0, D=0, Bout=0, V=0, internal shift registers=0, borrow flop=0. The partial operation is discarded.

## Timing
- Reset values of all outputs: busy=0, done=0, D=4'h0, Bout=0, V=0.
- Latency: start sampled at edge k gives busy=1 after edges k through k+3. Results update and done rises at edge k+4; done falls at edge k+5 unless the operation restarts.
- From an accepted start to done high is 5 cycles, counting the start cycle as cycle 0 and done high in cycle 5.
- Throughput with back-to-back starts: one result every 5 cycles.
- done and busy are never high in the same cycle.
- All outputs are driven directly from flops, with no combinational path from inputs.
- If rst and start are both high in the same cycle, rst wins.

## Test plan
- Unsigned subtraction without borrow: X=7, Y=3, Bin=0, pulse start → 5 cycles later done=1, D=4'h4, Bout=0, V=0. busy is high for exactly 4 cycles.
- Negative result: X=3, Y=7, Bin=0 → D=4'hC, Bout=1, V=0. Then X=0, Y=0, Bin=1 → D=4'hF, Bout=1, V=0.
- Signed overflow: X=8, Y=1, Bin=0 → D=4'h7, Bout=0, V=1. Then X=7, Y=4'hF, Bin=0 → D=4'h8, Bout=1, V=1.
- Start while busy: accept X=5, Y=2. Pulse start with X=9, Y=9 during S1 → a single done with D=4'h3. No second done follows. Outputs stay held afterwards.
- Reset mid-operation: assert rst for one cycle while in S2 → next cycle busy=0, done=0, D=0, Bout=0, V=0. No done pulse occurs until a new start is accepted.
- Back-to-back: hold start=1 with X=6, Y=1, then X=2, Y=3 presented in the first DONE cycle → done pulses 5 cycles apart. First result: D=4'h5, Bout=0. Second result: D=4'hF, Bout=1.

Source files
------------

// File: rtl/serial_4bits_subtractor.sv
// rtl/serial_4bits_subtractor.sv - bit-serial 4-bit subtractor D = X - Y - Bin, LSB first
//
// Purpose: computes one difference bit per clock over four cycles (S0..S3),
// with a start/busy/done handshake. Results are held until the next completion.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - operation request, sampled only in IDLE or DONE
//   X, Y   - 4-bit minuend / subtrahend, captured on the accepted start edge
//   Bin    - borrow-in, captured on the accepted start edge
//   busy   - high while bits are processed (S0..S3)
//   done   - one-cycle pulse while in DONE
//   D      - registered 4-bit difference (modulo 16)
//   Bout   - registered unsigned borrow-out
//   V      - registered two's-complement overflow
module serial_4bits_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] D,
  output logic       Bout,
  output logic       V
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] x_q, x_d;        // minuend shift register, LSB consumed first
  logic [3:0] y_q, y_d;        // subtrahend shift register
  logic [3:0] dsh_q, dsh_d;    // difference shift register, filled from the top
  logic       b_q, b_d;        // running borrow
  logic       xmsb_q, xmsb_d;  // operand sign bits kept for the overflow term
  logic       ymsb_q, ymsb_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] res_q, res_d;
  logic       bout_q, bout_d;
  logic       v_q, v_d;

  logic       diff_bit;
  logic       borrow_next;
  logic [3:0] dsh_shifted;

  assign diff_bit    = x_q[0] ^ y_q[0] ^ b_q;
  assign borrow_next = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);
  // After the fourth shift the register holds the full difference, bit 0 at the bottom.
  assign dsh_shifted = {diff_bit, dsh_q[3:1]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dsh_d   = dsh_q;
    b_d     = b_q;
    xmsb_d  = xmsb_q;
    ymsb_d  = ymsb_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    res_d   = res_q;
    bout_d  = bout_q;
    v_d     = v_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          x_d     = X;
          y_d     = Y;
          b_d     = Bin;
          xmsb_d  = X[3];
          ymsb_d  = Y[3];
          dsh_d   = 4'h0;
          state_d = ST_S0;
          busy_d  = 1'b1;
        end
      end
      ST_S0, ST_S1, ST_S2: begin
        x_d    = {1'b0, x_q[3:1]};
        y_d    = {1'b0, y_q[3:1]};
        dsh_d  = dsh_shifted;
        b_d    = borrow_next;
        busy_d = 1'b1;
        case (state_q)
          ST_S0:   state_d = ST_S1;
          ST_S1:   state_d = ST_S2;
          default: state_d = ST_S3;
        endcase
      end
      ST_S3: begin
        x_d     = {1'b0, x_q[3:1]};
        y_d     = {1'b0, y_q[3:1]};
        dsh_d   = dsh_shifted;
        b_d     = borrow_next;
        res_d   = dsh_shifted;
        bout_d  = borrow_next;
        // Overflow: operand signs differ and the result sign differs from X.
        v_d     = (xmsb_q ^ ymsb_q) & (diff_bit ^ xmsb_q);
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= 4'h0;
      y_q     <= 4'h0;
      dsh_q   <= 4'h0;
      b_q     <= 1'b0;
      xmsb_q  <= 1'b0;
      ymsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 4'h0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dsh_q   <= dsh_d;
      b_q     <= b_d;
      xmsb_q  <= xmsb_d;
      ymsb_q  <= ymsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = res_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule
